// File: rtl/sound_tone_gen_if.sv
// sound_tone_gen_if: sound-timer input and audio output bundle
interface sound_tone_gen_if;
    logic [7:0] sound_timer;
    logic       mute;
    logic       audio_pwm;
    logic       audio_sq;
    logic       active;
    modport master (output sound_timer, mute, input audio_pwm, audio_sq, active);
    modport slave (input sound_timer, mute, output audio_pwm, audio_sq, active);
endinterface

// File: rtl/sound_tone_gen.sv
// sound_tone_gen: CHIP-8 sound-timer square tone with enveloped PWM; attack/release ramps only with SOUND_RAMP_EN
module sound_tone_gen #(
    parameter int CLK_HZ           = 27000000,
    parameter int TONE_HZ          = 440,
    parameter int PWM_BITS         = 8,
    parameter int RAMP_STEP_CYCLES = 1024
) (
    input logic             clk,
    input logic             rst,
    sound_tone_gen_if.slave bus
);
    localparam int HALF = CLK_HZ / (2 * TONE_HZ);
    localparam int TW = $clog2(HALF);
    localparam logic [TW-1:0] TONE_LAST = TW'(HALF - 1);
    localparam logic [PWM_BITS-1:0] ENV_MAX = '1;
`ifdef SOUND_RAMP_EN
    localparam int SW = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(RAMP_STEP_CYCLES - 1);
`endif
    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;
    state_t              state_q, state_d;
    logic                gate_q, gate_d;
    logic [PWM_BITS-1:0] env_q, env_d, pwm_cnt_q, pwm_cnt_d;
    logic [TW-1:0]       tone_cnt_q, tone_cnt_d;
    logic                phase_q, phase_d, tone_wrap;
    logic                pwm_out_q, pwm_out_d, sq_q, sq_d, active_q, active_d;
`ifdef SOUND_RAMP_EN
    logic [SW-1:0]       step_cnt_q, step_cnt_d;
    logic                step_wrap;
`endif
    always_comb begin
        gate_d     = (bus.sound_timer != 8'h00) && !bus.mute;
        pwm_cnt_d  = pwm_cnt_q + 1'b1;
        tone_wrap  = tone_cnt_q == TONE_LAST;
        tone_cnt_d = (state_q == IDLE || tone_wrap) ? '0 : tone_cnt_q + 1'b1;
        phase_d    = (state_q != IDLE) && (phase_q ^ tone_wrap);
        pwm_out_d  = phase_q && (pwm_cnt_q < env_q);
        sq_d       = phase_q && (state_q == ATTACK || state_q == SUSTAIN);
        active_d   = state_q != IDLE;
        state_d    = state_q;
        env_d      = env_q;
`ifdef SOUND_RAMP_EN
        step_wrap  = step_cnt_q == STEP_LAST;
        step_cnt_d = step_wrap ? '0 : step_cnt_q + 1'b1;
`endif
        case (state_q)
            IDLE: begin
                env_d = '0;
                if (gate_q) begin
                    tone_cnt_d = '0;
                    phase_d    = 1'b1;
`ifdef SOUND_RAMP_EN
                    state_d    = ATTACK;
                    step_cnt_d = '0;
`else
                    state_d    = SUSTAIN;
                    env_d      = ENV_MAX;
`endif
                end
            end
            SUSTAIN: begin
                env_d = ENV_MAX;
                if (!gate_q) begin
`ifdef SOUND_RAMP_EN
                    state_d    = RELEASE;
                    step_cnt_d = '0;
`else
                    state_d    = IDLE;
                    env_d      = '0;
                    tone_cnt_d = '0;
                    phase_d    = 1'b0;
`endif
                end
            end
`ifdef SOUND_RAMP_EN
            ATTACK: begin
                if (!gate_q) begin
                    state_d    = RELEASE;
                    step_cnt_d = '0;
                end else begin
                    if (step_wrap && env_q != ENV_MAX) env_d = env_q + 1'b1;
                    if (env_d == ENV_MAX) state_d = SUSTAIN;
                end
            end
            RELEASE: begin
                if (gate_q) begin
                    state_d    = ATTACK;
                    step_cnt_d = '0;
                end else begin
                    if (step_wrap && env_q != '0) env_d = env_q - 1'b1;
                    if (env_d == '0) begin
                        state_d    = IDLE;
                        tone_cnt_d = '0;
                        phase_d    = 1'b0;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gate_q     <= 1'b0;
            env_q      <= '0;
            pwm_cnt_q  <= '0;
            tone_cnt_q <= '0;
            phase_q    <= 1'b0;
            pwm_out_q  <= 1'b0;
            sq_q       <= 1'b0;
            active_q   <= 1'b0;
`ifdef SOUND_RAMP_EN
            step_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gate_q     <= gate_d;
            env_q      <= env_d;
            pwm_cnt_q  <= pwm_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            phase_q    <= phase_d;
            pwm_out_q  <= pwm_out_d;
            sq_q       <= sq_d;
            active_q   <= active_d;
`ifdef SOUND_RAMP_EN
            step_cnt_q <= step_cnt_d;
`endif
        end
    end
    assign bus.audio_pwm = pwm_out_q;
    assign bus.audio_sq  = sq_q;
    assign bus.active    = active_q;
endmodule
